// File: rtl/lcd_marker_driver_if.sv
// LCD pin / frame-source / marker bundle for lcd_marker_driver.
// The driver takes the master side; pins, frame source and marker control take the slave side.
interface lcd_marker_driver_if #(
  parameter int DW    = 16,
  parameter int CW    = 11,
  parameter int NMARK = 5
);
  logic                  lcd_dclk;
  logic                  lcd_blank;
  logic                  lcd_sync;
  logic                  lcd_hs;
  logic                  lcd_vs;
  logic                  lcd_en;
  logic [DW-1:0]         lcd_rgb;
  logic                  lcd_request;
  logic                  lcd_framesync;
  logic [CW-1:0]         lcd_xpos;
  logic [CW-1:0]         lcd_ypos;
  logic [DW-1:0]         lcd_data;
  logic [NMARK*CW-1:0]   mark_x;
  logic [NMARK*CW-1:0]   mark_y;
  logic [NMARK-1:0]      mark_en;
  logic                  ovl_toggle;

  modport master (
    output lcd_dclk, lcd_blank, lcd_sync, lcd_hs, lcd_vs, lcd_en, lcd_rgb,
           lcd_request, lcd_framesync, lcd_xpos, lcd_ypos,
    input  lcd_data, mark_x, mark_y, mark_en, ovl_toggle
  );

  modport slave (
    input  lcd_dclk, lcd_blank, lcd_sync, lcd_hs, lcd_vs, lcd_en, lcd_rgb,
           lcd_request, lcd_framesync, lcd_xpos, lcd_ypos,
    output lcd_data, mark_x, mark_y, mark_en, ovl_toggle
  );
endinterface

// File: rtl/lcd_marker_driver.sv
// Parametrised LCD timing generator with frame-buffer requests and a crosshair marker overlay.
// Define LCD_MARK_OVERLAY_EN to build the overlay; otherwise lcd_rgb passes lcd_data through.
module lcd_marker_driver #(
  parameter int            H_DISP     = 640,
  parameter int            H_FP       = 16,
  parameter int            H_SYNC     = 96,
  parameter int            H_BP       = 48,
  parameter int            V_DISP     = 480,
  parameter int            V_FP       = 10,
  parameter int            V_SYNC     = 2,
  parameter int            V_BP       = 33,
  parameter int            DW         = 16,
  parameter int            CW         = 11,
  parameter int            NMARK      = 5,
  parameter int            MARK_R     = 4,
  parameter logic [DW-1:0] MARK_COLOR = 16'hF800
) (
  input  logic               clk,
  input  logic               rst,
  lcd_marker_driver_if.master bus
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int H_ACT0  = H_SYNC + H_BP;
  localparam int V_ACT0  = V_SYNC + V_BP;

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          h_act, v_act;
  logic          req_q, fsync_q, hs1_q, vs1_q;
  logic [CW-1:0] xpos_q, ypos_q;
  logic          hs_q, vs_q, en_q;

  always_comb begin
    h_cnt_d = h_cnt_q + CW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + CW'(1);
    end
  end

  assign h_act = (h_cnt_q >= CW'(H_ACT0)) && (h_cnt_q < CW'(H_ACT0 + H_DISP));
  assign v_act = (v_cnt_q >= CW'(V_ACT0)) && (v_cnt_q < CW'(V_ACT0 + V_DISP));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      req_q   <= 1'b0;
      fsync_q <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      req_q   <= h_act && v_act;
      fsync_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      xpos_q  <= (h_act && v_act) ? h_cnt_q - CW'(H_ACT0) : '0;
      ypos_q  <= (h_act && v_act) ? v_cnt_q - CW'(V_ACT0) : '0;
      hs1_q   <= ~(h_cnt_q < CW'(H_SYNC));
      vs1_q   <= ~(v_cnt_q < CW'(V_SYNC));
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
      en_q    <= req_q;
    end
  end

  assign bus.lcd_dclk      = ~clk;
  assign bus.lcd_sync      = 1'b0;
  assign bus.lcd_hs        = hs_q;
  assign bus.lcd_vs        = vs_q;
  assign bus.lcd_blank     = hs_q & vs_q;
  assign bus.lcd_en        = en_q;
  assign bus.lcd_request   = req_q;
  assign bus.lcd_framesync = fsync_q;
  assign bus.lcd_xpos      = xpos_q;
  assign bus.lcd_ypos      = ypos_q;

`ifdef LCD_MARK_OVERLAY_EN
  localparam logic signed [CW:0] R_P = (CW+1)'(MARK_R);
  localparam logic signed [CW:0] R_N = -R_P;

  logic [NMARK*CW-1:0] shx_q, shy_q;
  logic [NMARK-1:0]    shen_q;
  logic                ovl_on_q, ovl_sh_q, tog_q, tog_prev_q, hit_q, hit;
  logic [CW-1:0]       mx, my;
  logic signed [CW:0]  dx, dy;

  // Differences are taken one bit wider and signed so arms never wrap across the screen edge.
  always_comb begin
    hit = 1'b0;
    mx  = '0;
    my  = '0;
    dx  = '0;
    dy  = '0;
    for (int i = 0; i < NMARK; i++) begin
      mx = shx_q[i*CW +: CW];
      my = shy_q[i*CW +: CW];
      dx = $signed({1'b0, xpos_q}) - $signed({1'b0, mx});
      dy = $signed({1'b0, ypos_q}) - $signed({1'b0, my});
      if (shen_q[i] && (((ypos_q == my) && (dx >= R_N) && (dx <= R_P)) ||
                        ((xpos_q == mx) && (dy >= R_N) && (dy <= R_P))))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shx_q      <= '0;
      shy_q      <= '0;
      shen_q     <= '0;
      ovl_on_q   <= 1'b1;
      ovl_sh_q   <= 1'b1;
      tog_q      <= 1'b0;
      tog_prev_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      tog_q      <= bus.ovl_toggle;
      tog_prev_q <= tog_q;
      if (tog_q && !tog_prev_q)
        ovl_on_q <= ~ovl_on_q;
      if (fsync_q) begin
        shx_q    <= bus.mark_x;
        shy_q    <= bus.mark_y;
        shen_q   <= bus.mark_en;
        ovl_sh_q <= ovl_on_q;
      end
      hit_q <= hit;
    end
  end

  assign bus.lcd_rgb = en_q ? ((hit_q && ovl_sh_q) ? MARK_COLOR : bus.lcd_data) : '0;
`else
  logic unused_ovl;
  assign unused_ovl  = ^{bus.mark_x, bus.mark_y, bus.mark_en, bus.ovl_toggle};
  assign bus.lcd_rgb = en_q ? bus.lcd_data : '0;
`endif
endmodule

// File: tb/tb_lcd_marker_driver.sv
// Bench for lcd_marker_driver on a small 14x7 raster with a frame-level reference model.
module tb_lcd_marker_driver;
  localparam int HD = 8, HF = 2, HS = 2, HB = 2;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;
  localparam int HA0 = HS + HB, VA0 = VS + VB;
  localparam int DW = 16, CW = 8, NM = 2, MR = 1;
  localparam logic [15:0] COLOR = 16'hF800;
`ifdef LCD_MARK_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_marker_driver_if #(.DW(DW), .CW(CW), .NMARK(NM)) bus ();

  lcd_marker_driver #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .DW(DW), .CW(CW), .NMARK(NM), .MARK_R(MR), .MARK_COLOR(COLOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int failures = 0;
  int c = 0;              // cycles since the last reset edge
  int smx[NM], smy[NM];
  bit sen[NM];
  bit sovl = 1'b1;        // overlay state the next frame latch will capture
  bit pend = 1'b1;        // overlay state after all toggles seen so far
  logic [15:0] prev_xy = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, c);
    end
  endtask

  function automatic bit model_hit(int x, int y);
    for (int i = 0; i < NM; i++) begin
      if (sen[i] && ((y == smy[i] && x - smx[i] <= MR && smx[i] - x <= MR) ||
                     (x == smx[i] && y - smy[i] <= MR && smy[i] - y <= MR)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_cycle();
    int i1, i2, h, v, x, y;
    bit a, ereq, efs, ehs, evs, een;
    logic [7:0] ex, ey;
    logic [15:0] erg;
    ereq = 0; efs = 0; ehs = 1; evs = 1; een = 0; ex = '0; ey = '0; erg = '0;
    if (c >= 1) begin
      i1 = (c - 1) % FT; h = i1 % HT; v = i1 / HT;
      a = (h >= HA0 && h < HA0 + HD && v >= VA0 && v < VA0 + VD);
      ereq = a;
      efs = (i1 == 0);
      if (a) begin ex = 8'(h - HA0); ey = 8'(v - VA0); end
    end
    if (c >= 2) begin
      i2 = (c - 2) % FT; h = i2 % HT; v = i2 / HT;
      a = (h >= HA0 && h < HA0 + HD && v >= VA0 && v < VA0 + VD);
      ehs = (h >= HS);
      evs = (v >= VS);
      een = a;
      if (a) begin
        x = h - HA0; y = v - VA0;
        erg = (OVL && sovl && model_hit(x, y)) ? COLOR : {8'(x), 8'(y)};
      end
    end
    chk("request",   bus.lcd_request,   ereq);
    chk("framesync", bus.lcd_framesync, efs);
    chk("xpos",      bus.lcd_xpos,      ex);
    chk("ypos",      bus.lcd_ypos,      ey);
    chk("hs",        bus.lcd_hs,        ehs);
    chk("vs",        bus.lcd_vs,        evs);
    chk("blank",     bus.lcd_blank,     ehs & evs);
    chk("en",        bus.lcd_en,        een);
    chk("rgb",       bus.lcd_rgb,       erg);
    chk("sync",      bus.lcd_sync,      1'b0);
    chk("dclk",      bus.lcd_dclk,      1'b1);
    // Frame-start latch: whatever the marker inputs hold in this cycle is what the next frame shows.
    if (efs) begin
      for (int i = 0; i < NM; i++) begin
        smx[i] = int'(bus.mark_x[i*CW +: CW]);
        smy[i] = int'(bus.mark_y[i*CW +: CW]);
        sen[i] = bus.mark_en[i];
      end
      sovl = pend;
    end
    prev_xy = {bus.lcd_xpos, bus.lcd_ypos};
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    if (rst) begin
      c = 0;
      for (int i = 0; i < NM; i++) sen[i] = 1'b0;
      pend = 1'b1;
      sovl = 1'b1;
    end else begin
      c++;
    end
    #1;
    bus.lcd_data = prev_xy;
  endtask

  task automatic run_to(input int pos);
    int n = 0;
    do begin
      step();
      n++;
    end while ((c % FT) != pos && n < 2 * FT);
    chk("run_to_bound", ((c % FT) == pos), 1'b1);
  endtask

  task automatic set_mark(input int i, input int x, input int y, input bit en);
    bus.mark_x[i*CW +: CW] = 8'(x);
    bus.mark_y[i*CW +: CW] = 8'(y);
    bus.mark_en[i] = en;
  endtask

  task automatic set_toggle(input bit val);
    if (val && !bus.ovl_toggle) pend = ~pend;
    bus.ovl_toggle = val;
  endtask

  initial begin
    bus.lcd_data = '0;
    bus.mark_x = '0;
    bus.mark_y = '0;
    bus.mark_en = '0;
    bus.ovl_toggle = 1'b0;
    for (int i = 0; i < NM; i++) begin smx[i] = 0; smy[i] = 0; sen[i] = 1'b0; end
    @(posedge clk);
    #1;
    repeat (3) step();
    rst = 1'b0;

    // first frame: pure timing and data alignment, then cross at (3,2) and corner marker at (0,0)
    run_to(50);
    set_mark(0, 3, 2, 1'b1);
    set_mark(1, 0, 0, 1'b1);
    run_to(1);
    run_to(50);
    set_mark(0, 5, 2, 1'b1);
    run_to(1);
    run_to(40);
    set_toggle(1'b1);
    run_to(60);
    set_toggle(1'b0);
    run_to(1);
    run_to(40);
    set_toggle(1'b1);
    run_to(60);
    set_toggle(1'b0);
    run_to(1);

    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < NM; i++)
          set_mark(i, $urandom_range(0, 9), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      run_to($urandom_range(10, 40));
      for (int i = 0; i < NM; i++)
        set_mark(i, $urandom_range(0, 9), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      set_toggle(1'($urandom_range(0, 1)));
      run_to($urandom_range(45, 80));
      set_toggle(1'b0);
      run_to(1);
    end

    // reset while counters sit at line 2, pixel 4
    set_mark(0, 3, 2, 1'b1);
    run_to(2 * HT + 4);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    run_to(1);
    run_to(90);
    run_to(1);
    run_to(90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_marker_driver.md
# lcd_marker_driver

Parametrised LCD/VGA timing generator with frame-buffer request interface and an N-marker crosshair overlay. It replaces the fixed-resolution driver with fixed corner inputs: timing, pixel width and marker count are parameters, marker sets are double-buffered per frame, and the overlay can be toggled at run time. It sits between the SDRAM read FIFO and the LCD/DAC pins.

## Interface
- H_DISP, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in clocks
- V_DISP, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- DW, 16, pixel width in bits (RGB565 at 16)
- CW, 11, coordinate width
- NMARK, 5, number of markers
- MARK_R, 4, crosshair arm length in pixels
- MARK_COLOR, 16'hF800, overlay colour, DW bits

Ports:
- clk  in  1  pixel clock; one pixel per cycle
- rst  in  1  synchronous, active-high reset
- lcd_dclk  out  1  ~clk
- lcd_blank  out  1  lcd_hs & lcd_vs
- lcd_sync  out  1  constant 0
- lcd_hs / lcd_vs  out  1  active-low syncs
- lcd_en  out  1  active-pixel qualifier
- lcd_rgb  out  DW  pixel data
- lcd_request  out  1  pixel request to frame source
- lcd_framesync  out  1  one-cycle frame-start pulse
- lcd_xpos / lcd_ypos  out  CW  coordinates of the requested pixel
- lcd_data  in  DW  pixel data, valid one cycle after lcd_request
- mark_x / mark_y  in  NMARK*CW  packed marker centres; marker i is at [i*CW +: CW]
- mark_en  in  NMARK  per-marker enable
- ovl_toggle  in  1  level input; each rising edge toggles the overlay

## Operation
- **Counters.** h_cnt runs 0..H_TOTAL-1, with H_TOTAL = H_SYNC+H_BP+H_DISP+H_FP. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- **Line and frame order.** Each line and frame is ordered sync, back porch, display, front porch.
- **Active region.** Active when h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_DISP) and v_cnt is in the vertical equivalent range.
- **Stage 1 (registered from counters).**
  - lcd_request = active.
  - lcd_xpos / lcd_ypos = offsets into the active region; 0 when not active.
  - lcd_framesync = (h_cnt==0 && v_cnt==0).
- **Frame-start latch.** On a cycle where lcd_framesync is high, latch mark_x, mark_y, mark_en and ovl_on into shadow registers. The overlay uses only the shadows, so it is tear-free.
- **Toggle.** ovl_toggle is registered. On a rising edge, ovl_on inverts. The change takes effect at the next framesync latch.
- **Stage 2 (registered from stage 1).**
  - lcd_hs = ~(h_cnt in sync region), delayed 2 cycles.
  - lcd_vs is derived the same way, delayed 2 cycles.
  - lcd_en = lcd_request delayed 1 cycle.
  - lcd_rgb = 0 when not enabled. Otherwise MARK_COLOR when hit && shadow ovl_on, else lcd_data.
- **Hit test.** Evaluated on stage-1 coordinates against the shadow markers, using signed (CW+1)-bit differences.
  - A pixel is a hit for enabled marker i if (y==my_i && |x-mx_i|<=MARK_R) or (x==mx_i && |y-my_i|<=MARK_R).
  - There is no wrap: arms past the display edge are clipped.
  - Overlapping markers produce the same colour, so no priority is needed.

## Timing
- **Reset values.** lcd_hs=1, lcd_vs=1, lcd_blank=1, lcd_en=0, lcd_rgb=0, lcd_request=0, lcd_framesync=0, lcd_xpos=0, lcd_ypos=0, ovl_on=1, shadow mark_en=0, counters=0.
- **First cycle after rst falls.** Counters are at (0,0). lcd_framesync pulses on the following cycle.
- **Latency.** Counter state to request/xpos/framesync: 1 cycle. Counter state to hs/vs/en/rgb: 2 cycles. lcd_data is consumed exactly 1 cycle after its lcd_request.
- **Reset mid-frame.** All outputs return to their reset values on the next clock. The frame restarts from (0,0). Shadows are cleared, so no markers appear until the next latch.
- **Simultaneous events.**
  - If an ovl_toggle edge and framesync occur in the same cycle, the latch captures the pre-toggle ovl_on.
  - A mark_* change in the framesync cycle is captured.

## Configuration
- **LCD_MARK_OVERLAY_EN defined:** the overlay, shadow registers, hit test and toggle logic are built as described above.
- **LCD_MARK_OVERLAY_EN undefined:** lcd_rgb = lcd_data when lcd_en, else 0. mark_*, mark_en and ovl_toggle are ignored. Timing, latency and all other outputs are identical.

## Test plan
All scenarios use H_DISP=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_DISP=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); MARK_R=1; macro defined unless noted.
- **Reset/timing.** Release rst at cycle 0.
  - lcd_hs is low for cycles 2–3, then low for 2 of every 14 cycles.
  - lcd_vs is low for the first 14 cycles from cycle 2.
  - lcd_en is high for 8 consecutive cycles on each of 4 lines per 98-cycle frame.
  - lcd_framesync is high at cycle 1 and cycle 99.
- **Alignment.** Drive lcd_data = {xpos,ypos} registered from the previous cycle's lcd_xpos/lcd_ypos, with no markers enabled.
  - lcd_rgb equals the pixel's coordinates at every lcd_en cycle.
  - lcd_en rises exactly 1 cycle after lcd_request.
- **Cross.** Marker0 at (3,2), enabled, before framesync.
  - In the next frame, lcd_rgb=MARK_COLOR at (2,2), (3,2), (4,2), (3,1) and (3,3).
  - All other pixels show lcd_data.
- **Edge clipping.** Marker at (0,0).
  - Hits at (0,0), (1,0) and (0,1) only.
  - No hit at (7,0) or (0,3).
- **Double-buffer and toggle.**
  - Moving mark_x mid-frame has no visible effect until the next frame.
  - An ovl_toggle rising edge mid-frame leaves the current frame overlaid; the next frame shows pure lcd_data.
- **Reset mid-frame and macro off.**
  - Assert rst at line 2, pixel 4: all outputs are at reset values on the next cycle.
  - With the macro undefined, the Cross scenario yields pure lcd_data.
